// File: rtl/frame_capture_pkg.sv
// Shared types and constants for the ping-pong frame capture controller.
package frame_capture_pkg;

    typedef enum logic [1:0] {
        WAIT_FV_LOW = 2'd0,
        IDLE        = 2'd1,
        CAPTURE     = 2'd2
    } state_e;

    typedef logic bank_t;

    localparam int DEF_WIDTH        = 752;
    localparam int DEF_HEIGHT       = 480;
    localparam int PIXELS_PER_FRAME = DEF_WIDTH * DEF_HEIGHT;

    function automatic int pixels_per_frame(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/frame_capture_bank_pool.sv
// Two-bank full/free bookkeeping: bank pick at frame start, mark on completion, release by consumer.
module frame_capture_bank_pool
    import frame_capture_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       release_i,
    input  bank_t      release_bank_i,
    input  logic       mark_i,
    input  bank_t      mark_bank_i,
    output logic [1:0] full_o,
    output logic       free_any_o,
    output bank_t      pick_o
);

    logic [1:0] full_q;
    logic [1:0] full_d;
    logic [1:0] rel_mask_s;
    logic [1:0] mark_mask_s;
    logic [1:0] avail_s;
    bank_t      last_q;
    bank_t      last_d;

    // A bank released this cycle already counts as free for a frame starting this cycle.
    always_comb begin
        rel_mask_s  = release_i ? (2'b01 << release_bank_i) : 2'b00;
        mark_mask_s = mark_i    ? (2'b01 << mark_bank_i)    : 2'b00;
        avail_s     = ~full_q | rel_mask_s;
        free_any_o  = |avail_s;
        pick_o      = avail_s[~last_q] ? ~last_q : last_q;
        full_d      = (full_q & ~rel_mask_s) | mark_mask_s;
        last_d      = mark_i ? mark_bank_i : last_q;
    end

    // Full flags and most recently completed bank.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_q <= 2'b00;
            last_q <= 1'b1;
        end else begin
            full_q <= full_d;
            last_q <= last_d;
        end
    end

    assign full_o = full_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: arms per frame, streams pixels into a free bank with a 1-cycle
// registered write port, and reports completed, discarded and dropped frames.
module frame_capture_ctrl
    import frame_capture_pkg::*;
#(
    parameter int WIDTH     = 752,
    parameter int HEIGHT    = 480,
    parameter int DATA_BITS = 10,
    parameter int LINE_BITS = 9,
    parameter int COL_BITS  = 10,
    parameter int ADDR_BITS = 19
) (
    input  logic                 PIXCLK,
    input  logic                 RST_N,
    input  logic                 FRAME_VALID,
    input  logic                 PIXEL_VALID,
    input  logic [LINE_BITS-1:0] CURRENT_LINE,
    input  logic [COL_BITS-1:0]  CURRENT_COLUMN,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 CONTINUOUS,
    input  logic                 CAPTURE_REQ,
    input  logic                 RELEASE,
    input  logic                 RELEASE_BANK,
    output logic                 WR_EN,
    output logic                 WR_BANK,
    output logic [ADDR_BITS-1:0] WR_ADDR,
    output logic [DATA_BITS-1:0] WR_DATA,
    output logic                 FRAME_DONE,
    output logic                 DONE_BANK,
    output logic [1:0]           FULL_BANKS,
    output logic                 FRAME_ERR,
    output logic [7:0]           DROP_CNT,
    output logic                 BUSY
);

    localparam int CNT_BITS = ADDR_BITS + 1;
    localparam logic [CNT_BITS-1:0]  PPF_C        = CNT_BITS'(pixels_per_frame(WIDTH, HEIGHT));
    localparam logic [LINE_BITS:0]   HEIGHT_C     = (LINE_BITS + 1)'(HEIGHT);
    localparam logic [COL_BITS:0]    WIDTH_COL_C  = (COL_BITS + 1)'(WIDTH);
    localparam logic [ADDR_BITS-1:0] WIDTH_ADDR_C = ADDR_BITS'(WIDTH);

    state_e                 state_q;
    bank_t                  bank_q;
    logic                   arm_q;
    logic                   bad_q;
    logic [CNT_BITS-1:0]    cnt_q;
    logic                   wr_en_q;
    bank_t                  wr_bank_q;
    logic [ADDR_BITS-1:0]   wr_addr_q;
    logic [DATA_BITS-1:0]   wr_data_q;
    logic                   frame_done_q;
    bank_t                  done_bank_q;
    logic                   frame_err_q;
    logic [7:0]             drop_q;
    logic                   busy_q;

    logic                   fv_rise_s;
    logic                   armed_s;
    logic                   start_s;
    logic                   drop_s;
    logic                   fv_fall_s;
    logic                   pix_go_s;
    logic                   in_range_s;
    logic                   pix_wr_s;
    logic                   pix_bad_s;
    logic                   done_s;
    logic                   err_s;
    bank_t                  cur_bank_s;
    logic [CNT_BITS-1:0]    cnt_base_s;
    logic                   bad_base_s;
    logic [ADDR_BITS-1:0]   addr_s;
    logic                   free_any_s;
    bank_t                  pick_s;
    logic [1:0]             full_s;

    frame_capture_bank_pool u_pool (
        .clk_i          (PIXCLK),
        .rst_n_i        (RST_N),
        .release_i      (RELEASE),
        .release_bank_i (RELEASE_BANK),
        .mark_i         (done_s),
        .mark_bank_i    (bank_q),
        .full_o         (full_s),
        .free_any_o     (free_any_s),
        .pick_o         (pick_s)
    );

    // Frame start/end decisions and per-pixel qualification; a pixel on the start cycle joins the new frame.
    always_comb begin
        fv_rise_s  = (state_q == IDLE) && FRAME_VALID;
        armed_s    = CONTINUOUS || arm_q;
        start_s    = fv_rise_s && armed_s && free_any_s;
        drop_s     = fv_rise_s && armed_s && !free_any_s;
        fv_fall_s  = (state_q == CAPTURE) && !FRAME_VALID;
        pix_go_s   = PIXEL_VALID && (start_s || ((state_q == CAPTURE) && FRAME_VALID));
        if (start_s) begin
            cur_bank_s = pick_s;
            cnt_base_s = {CNT_BITS{1'b0}};
            bad_base_s = 1'b0;
        end else begin
            cur_bank_s = bank_q;
            cnt_base_s = cnt_q;
            bad_base_s = bad_q;
        end
        in_range_s = ({1'b0, CURRENT_LINE} < HEIGHT_C) && ({1'b0, CURRENT_COLUMN} < WIDTH_COL_C);
        pix_wr_s   = pix_go_s && in_range_s && (cnt_base_s < PPF_C);
        pix_bad_s  = pix_go_s && !pix_wr_s;
        done_s     = fv_fall_s && (cnt_q == PPF_C) && !bad_q;
        err_s      = fv_fall_s && !done_s;
        addr_s     = ADDR_BITS'(CURRENT_LINE) * WIDTH_ADDR_C + ADDR_BITS'(CURRENT_COLUMN);
    end

    // Capture FSM with registered write port, status pulses and drop counter.
    always_ff @(posedge PIXCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= WAIT_FV_LOW;
            bank_q       <= 1'b0;
            arm_q        <= 1'b0;
            bad_q        <= 1'b0;
            cnt_q        <= {CNT_BITS{1'b0}};
            wr_en_q      <= 1'b0;
            wr_bank_q    <= 1'b0;
            wr_addr_q    <= {ADDR_BITS{1'b0}};
            wr_data_q    <= {DATA_BITS{1'b0}};
            frame_done_q <= 1'b0;
            done_bank_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            drop_q       <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            wr_en_q      <= pix_wr_s;
            frame_done_q <= done_s;
            frame_err_q  <= err_s;
            if (pix_wr_s) begin
                wr_bank_q <= cur_bank_s;
                wr_addr_q <= addr_s;
                wr_data_q <= DATA_IN;
            end
            if (done_s) begin
                done_bank_q <= bank_q;
                arm_q       <= CAPTURE_REQ;
            end else if (CAPTURE_REQ) begin
                arm_q <= 1'b1;
            end
            if (drop_s && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            if (start_s || (state_q == CAPTURE)) begin
                cnt_q <= cnt_base_s + {{(CNT_BITS-1){1'b0}}, pix_wr_s};
                bad_q <= bad_base_s | pix_bad_s;
            end
            if (start_s) begin
                bank_q <= pick_s;
            end
            case (state_q)
                WAIT_FV_LOW: begin
                    if (!FRAME_VALID) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (start_s) begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b1;
                    end else if (FRAME_VALID) begin
                        state_q <= WAIT_FV_LOW;
                    end
                end
                CAPTURE: begin
                    if (!FRAME_VALID) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= WAIT_FV_LOW;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign WR_EN      = wr_en_q;
    assign WR_BANK    = wr_bank_q;
    assign WR_ADDR    = wr_addr_q;
    assign WR_DATA    = wr_data_q;
    assign FRAME_DONE = frame_done_q;
    assign DONE_BANK  = done_bank_q;
    assign FULL_BANKS = full_s;
    assign FRAME_ERR  = frame_err_q;
    assign DROP_CNT   = drop_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl on a 2x3 frame: directed frame table, reset/corner sequences,
// and randomized frames checked against a frame-level model of banks, arming and drops.
module tb_frame_capture_ctrl;

    localparam int W   = 2;
    localparam int H   = 3;
    localparam int PPF = W * H;

    logic        clk;
    logic        rst_n;
    logic        fv;
    logic        pv;
    logic [8:0]  line;
    logic [9:0]  col;
    logic [9:0]  data;
    logic        cont;
    logic        req;
    logic        rel;
    logic        rel_b;
    logic        wr_en;
    logic        wr_bank;
    logic [18:0] wr_addr;
    logic [9:0]  wr_data;
    logic        frame_done;
    logic        done_bank;
    logic [1:0]  full_banks;
    logic        frame_err;
    logic [7:0]  drop_cnt;
    logic        busy;

    frame_capture_ctrl #(
        .WIDTH(W), .HEIGHT(H), .DATA_BITS(10), .LINE_BITS(9), .COL_BITS(10), .ADDR_BITS(19)
    ) dut (
        .PIXCLK(clk), .RST_N(rst_n), .FRAME_VALID(fv), .PIXEL_VALID(pv),
        .CURRENT_LINE(line), .CURRENT_COLUMN(col), .DATA_IN(data),
        .CONTINUOUS(cont), .CAPTURE_REQ(req), .RELEASE(rel), .RELEASE_BANK(rel_b),
        .WR_EN(wr_en), .WR_BANK(wr_bank), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .FRAME_DONE(frame_done), .DONE_BANK(done_bank), .FULL_BANKS(full_banks),
        .FRAME_ERR(frame_err), .DROP_CNT(drop_cnt), .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       cont;
        bit       req;
        bit       rg;
        bit       rg_b;
        bit       rr;
        bit       rr_b;
        bit       rf;
        bit       rf_b;
        int       kind;   // 0 good, 1 short, 2 long, 3 out-of-range, 4 no pixels
        bit       e_done;
        bit       e_bank;
        bit       e_err;
        bit [1:0] e_full;
        int       e_drop;
    } row_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: bank occupancy, last completed bank, arm latch, drop count, current frame.
    bit [1:0] m_full;
    bit       m_last;
    bit       m_latch;
    bit       m_cap;
    bit       m_bank;
    bit       m_bad;
    int       m_cnt;
    int       m_drop;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_full  = 2'b00;
        m_last  = 1'b1;
        m_latch = 1'b0;
        m_cap   = 1'b0;
        m_drop  = 0;
    endtask

    task automatic px_step(input int l, input int c, input bit pvv, input bit rnd);
        bit exp_wr;
        int d;
        exp_wr = 1'b0;
        d = rnd ? int'($urandom_range(0, 1023)) : (l + 1) * 10 + (c + 1);
        line = 9'(l);
        col  = 10'(c);
        data = 10'(d);
        pv   = pvv;
        if (pvv && m_cap) begin
            if (l < H && c < W && m_cnt < PPF) begin
                exp_wr = 1'b1;
                m_cnt++;
            end else begin
                m_bad = 1'b1;
            end
        end
        step();
        pv = 1'b0;
        chk("wr_en", 32'(wr_en), 32'(exp_wr));
        if (exp_wr) begin
            chk("wr_bank", 32'(wr_bank), 32'(m_bank));
            chk("wr_addr", 32'(wr_addr), l * W + c);
            chk("wr_data", 32'(wr_data), d);
        end
        chk("busy", 32'(busy), 32'(m_cap));
    endtask

    task automatic run_frame(input row_t f, input bit rnd, output bit g_done, output bit g_bank, output bit g_err);
        bit exp_done;
        bit exp_err;
        fv = 1'b0; cont = f.cont; req = f.req; rel = f.rg; rel_b = f.rg_b;
        if (f.req) m_latch = 1'b1;
        if (f.rg) m_full[f.rg_b] = 1'b0;
        step();
        req = 1'b0; rel = 1'b0;
        chk("done_one_cycle", 32'(frame_done), 32'd0);
        chk("err_one_cycle", 32'(frame_err), 32'd0);
        chk("full_gap", 32'(full_banks), 32'(m_full));
        step();
        // frame start
        fv = 1'b1; rel = f.rr; rel_b = f.rr_b;
        if (f.rr) m_full[f.rr_b] = 1'b0;
        m_cap = 1'b0;
        if (f.cont || m_latch) begin
            if (m_full != 2'b11) begin
                m_cap  = 1'b1;
                m_bank = (m_full[~m_last] == 1'b0) ? ~m_last : m_last;
                m_cnt  = 0;
                m_bad  = 1'b0;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        step();
        rel = 1'b0;
        chk("busy_start", 32'(busy), 32'(m_cap));
        chk("drop_cnt", 32'(drop_cnt), m_drop);
        if (f.kind != 4) begin
            for (int l = 0; l < ((f.kind == 1) ? H - 1 : H); l++) begin
                for (int c = 0; c < W; c++) begin
                    px_step(l, c, 1'b1, rnd);
                    if ($urandom_range(0, 1) == 1) px_step(0, 0, 1'b0, rnd);
                    if (f.kind == 3 && l == 0 && c == 0) begin
                        if ($urandom_range(0, 1) == 1) px_step(0, W, 1'b1, rnd);
                        else px_step(H, 0, 1'b1, rnd);
                    end
                end
            end
            if (f.kind == 2) px_step(0, 0, 1'b1, rnd);
        end
        px_step(0, 0, 1'b0, rnd);
        // frame end
        fv = 1'b0;
        if (f.rf && !(m_cap && f.rf_b == m_bank)) begin
            rel = 1'b1; rel_b = f.rf_b;
            m_full[f.rf_b] = 1'b0;
        end
        exp_done = m_cap && (m_cnt == PPF) && !m_bad;
        exp_err  = m_cap && !exp_done;
        if (exp_done) begin
            m_full[m_bank] = 1'b1;
            m_last  = m_bank;
            m_latch = 1'b0;
        end
        step();
        rel = 1'b0;
        g_done = frame_done; g_bank = done_bank; g_err = frame_err;
        chk("frame_done", 32'(frame_done), 32'(exp_done));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        if (exp_done) chk("done_bank", 32'(done_bank), 32'(m_bank));
        chk("full_end", 32'(full_banks), 32'(m_full));
        chk("busy_end", 32'(busy), 32'd0);
        m_cap = 1'b0;
    endtask

    row_t tbl[16];

    initial begin
        row_t f;
        bit   gd;
        bit   gb;
        bit   ge;
        //           cont  req   rg    rgb   rr    rrb   rf    rfb  kind e_done e_bank e_err e_full e_drop
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 2'b01, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b11, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b11, 1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 2'b11, 1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 2'b01, 1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b01, 1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b11, 1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b11, 1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2'b01, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b11, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 2'b11, 1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 2'b01, 1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 2'b01, 1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 2'b01, 1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b11, 1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b11, 1};

        // Out of reset in the middle of a frame.
        rst_n = 1'b0; fv = 1'b1; pv = 1'b0; line = 9'd0; col = 10'd0; data = 10'd0;
        cont = 1'b1; req = 1'b0; rel = 1'b0; rel_b = 1'b0;
        model_reset();
        step(); step();
        rst_n = 1'b1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_full", 32'(full_banks), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        px_step(1, 0, 1'b1, 1'b0);
        px_step(1, 1, 1'b1, 1'b0);
        px_step(2, 0, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run_frame(tbl[i], 1'b0, gd, gb, ge);
            chk($sformatf("row%0d_done", i), 32'(gd), 32'(tbl[i].e_done));
            if (tbl[i].e_done) chk($sformatf("row%0d_bank", i), 32'(gb), 32'(tbl[i].e_bank));
            chk($sformatf("row%0d_err", i), 32'(ge), 32'(tbl[i].e_err));
            chk($sformatf("row%0d_full", i), 32'(full_banks), 32'(tbl[i].e_full));
            chk($sformatf("row%0d_drop", i), 32'(drop_cnt), tbl[i].e_drop);
        end

        // Reset three pixels into a capture.
        fv = 1'b0; cont = 1'b1; rel = 1'b1; rel_b = 1'b0;
        m_full[0] = 1'b0;
        step();
        rel = 1'b0;
        step();
        fv = 1'b1;
        m_cap = 1'b1; m_bank = 1'b0; m_cnt = 0; m_bad = 1'b0;
        step();
        chk("rst_seq_busy", 32'(busy), 32'd1);
        px_step(0, 0, 1'b1, 1'b0);
        px_step(0, 1, 1'b1, 1'b0);
        px_step(1, 0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_wr_en", 32'(wr_en), 32'd0);
        chk("async_rst_full", 32'(full_banks), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_drop", 32'(drop_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        px_step(1, 1, 1'b1, 1'b0);
        px_step(2, 0, 1'b1, 1'b0);
        px_step(2, 1, 1'b1, 1'b0);
        run_frame(tbl[0], 1'b0, gd, gb, ge);
        chk("post_rst_done", 32'(gd), 32'd1);
        chk("post_rst_bank", 32'(gb), 32'd0);
        chk("post_rst_full", 32'(full_banks), 32'd1);

        // Randomized frames.
        for (int i = 0; i < 40; i++) begin
            f = tbl[0];
            f.cont = ($urandom_range(0, 3) != 0);
            f.req  = ($urandom_range(0, 3) == 0);
            f.rg   = ($urandom_range(0, 2) == 0);
            f.rg_b = 1'($urandom_range(0, 1));
            f.rr   = ($urandom_range(0, 4) == 0);
            f.rr_b = 1'($urandom_range(0, 1));
            f.rf   = ($urandom_range(0, 3) == 0);
            f.rf_b = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                6: f.kind = 1;
                7: f.kind = 2;
                8: f.kind = 3;
                9: f.kind = 4;
                default: f.kind = 0;
            endcase
            run_frame(f, 1'b1, gd, gb, ge);
        end

        // Drop counter saturation with both banks held.
        f = tbl[0];
        for (int k = 0; k < 4 && m_full != 2'b11; k++) run_frame(f, 1'b1, gd, gb, ge);
        f.kind = 4;
        for (int k = 0; k < 260; k++) run_frame(f, 1'b1, gd, gb, ge);
        chk("drop_saturated", 32'(drop_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
